// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operation encoding and IEEE-754 single-precision field sizes.
package fpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3
    } Operation_t;

    localparam int EXP_SIZE  = 8;
    localparam int MANT_SIZE = 23;
    localparam int BIAS      = 127;

endpackage

// File: rtl/fpu_timeout_counter.sv
// Watchdog for the driver's FPU handshake states; expired fires on the TIMEOUT-th enabled cycle.
module fpu_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q;

    always_ff @(posedge clock) begin
        if (!reset || clear) cnt_q <= '0;
        else if (enable)     cnt_q <= cnt_q + 16'd1;
    end

    assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/fpu_driver.sv
// Single-transaction bridge between a command/response stream and a handshaked FPU,
// with a watchdog that turns a stalled FPU into an error response.
import fpu_pkg::*;

module fpu_driver #(
    parameter int bitness = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [bitness-1:0] cmd_a,
    input  logic [bitness-1:0] cmd_b,
    input  logic [3:0]         cmd_op,
    output logic               fpu_input_rdy,
    input  logic               fpu_input_ack,
    output logic [bitness-1:0] fpu_data_a,
    output logic [bitness-1:0] fpu_data_b,
    output logic [3:0]         fpu_operation,
    input  logic               fpu_output_rdy,
    output logic               fpu_output_ack,
    input  logic [bitness-1:0] fpu_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [bitness-1:0] rsp_result,
    output logic               rsp_error,
    output logic [15:0]        done_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_DELIVER = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [bitness-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    Operation_t         op_q, op_d;
    logic               irdy_q, irdy_d, oack_q, oack_d;
    logic               vld_q, vld_d, err_q, err_d;
    logic [15:0]        done_q, done_d;

    logic wd_busy, wd_clear, wd_expired;

    // Watchdog restarts on every entry into ISSUE or WAIT_RESULT
    assign wd_busy  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign wd_clear = !wd_busy || (state_d != state_q);

    fpu_timeout_counter #(.TIMEOUT(TIMEOUT)) u_wd (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_busy),
        .expired (wd_expired)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        irdy_d   = irdy_q;
        oack_d   = oack_q;
        vld_d    = vld_q;
        err_d    = err_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    op_d    = Operation_t'(cmd_op);
                    irdy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (fpu_input_ack) begin
                    irdy_d  = 1'b0;
                    state_d = S_WAIT;
                end else if (wd_expired) begin
                    irdy_d   = 1'b0;
                    result_d = '0;
                    err_d    = 1'b1;
                    vld_d    = 1'b1;
                    state_d  = S_DELIVER;
                end
            end
            S_WAIT: begin
                if (fpu_output_rdy) begin
                    result_d = fpu_result;
                    oack_d   = 1'b1;
                    state_d  = S_ACK;
                end else if (wd_expired) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    vld_d    = 1'b1;
                    state_d  = S_DELIVER;
                end
            end
            S_ACK: begin
                oack_d  = 1'b0;
                vld_d   = 1'b1;
                err_d   = 1'b0;
                done_d  = done_q + 16'd1;
                state_d = S_DELIVER;
            end
            S_DELIVER: begin
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            result_q <= '0;
            irdy_q   <= 1'b0;
            oack_q   <= 1'b0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            irdy_q   <= irdy_d;
            oack_q   <= oack_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign fpu_input_rdy  = irdy_q;
    assign fpu_data_a     = a_q;
    assign fpu_data_b     = b_q;
    assign fpu_operation  = op_q;
    assign fpu_output_ack = oack_q;
    assign rsp_valid      = vld_q;
    assign rsp_result     = result_q;
    assign rsp_error      = err_q;
    assign done_count     = done_q;

endmodule
